// File: rtl/ajuste_pkg.sv
// Shared field codes, FSM encodings and default timing for the RTC set-mode controller.
package ajuste_pkg;

  localparam logic [3:0] F_NONE = 4'd0;
  localparam logic [3:0] F_SS   = 4'd1;
  localparam logic [3:0] F_MM   = 4'd2;
  localparam logic [3:0] F_HH   = 4'd3;
  localparam logic [3:0] F_DD   = 4'd4;
  localparam logic [3:0] F_MES  = 4'd5;
  localparam logic [3:0] F_AA   = 4'd6;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_PROG = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_t;

  localparam int DEF_N_FIELDS  = 6;
  localparam int DEF_HOLD_DLY  = 50000000;
  localparam int DEF_RPT_PER   = 12500000;
  localparam int DEF_TIMEOUT   = 1000000000;
  localparam int DEF_BLINK_PER = 25000000;
  localparam int DEF_CW        = 30;

endpackage

// File: rtl/gen_autorepeat.sv
// Up/down strobe generator with press-and-hold repeat (repeat timer only when AUTOREPEAT_EN is defined).
// Strobes are registered and one cycle wide; enable low or clear high forces R_IDLE with no strobe.
module gen_autorepeat
  import ajuste_pkg::*;
`ifdef AUTOREPEAT_EN
#(
  parameter int HOLD_DLY = DEF_HOLD_DLY,
  parameter int RPT_PER  = DEF_RPT_PER,
  parameter int CW       = DEF_CW
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic btn_up,
  input  logic btn_down,
  input  logic up_edge,
  input  logic dn_edge,
  output logic up_pls,
  output logic dn_pls
);

  rep_t state, state_nxt;
  logic dir_up, dir_up_nxt;
  logic block, block_nxt;
  logic fire;
  logic up_nxt, dn_nxt;
  logic both_hi, held, other_hi;
`ifdef AUTOREPEAT_EN
  logic [CW-1:0] tmr, tmr_nxt;
`endif

  assign both_hi  = btn_up & btn_down;
  assign held     = dir_up ? btn_up : btn_down;
  assign other_hi = dir_up ? btn_down : btn_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= R_IDLE;
      dir_up <= 1'b0;
      block  <= 1'b0;
      up_pls <= 1'b0;
      dn_pls <= 1'b0;
`ifdef AUTOREPEAT_EN
      tmr    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      dir_up <= dir_up_nxt;
      block  <= block_nxt;
      up_pls <= up_nxt;
      dn_pls <= dn_nxt;
`ifdef AUTOREPEAT_EN
      tmr    <= tmr_nxt;
`endif
    end
  end

  // Once both buttons are seen high, a new press needs both released first.
  always_comb begin
    state_nxt  = state;
    dir_up_nxt = dir_up;
    block_nxt  = both_hi | (block & (btn_up | btn_down));
    fire       = 1'b0;
`ifdef AUTOREPEAT_EN
    tmr_nxt    = tmr;
`endif
    case (state)
      R_IDLE: begin
        if (!block && !both_hi && (up_edge ^ dn_edge)) begin
          state_nxt  = R_DELAY;
          dir_up_nxt = up_edge;
          fire       = 1'b1;
`ifdef AUTOREPEAT_EN
          tmr_nxt    = '0;
`endif
        end
      end
      R_DELAY: begin
        if (!held || other_hi) begin
          state_nxt = R_IDLE;
`ifdef AUTOREPEAT_EN
        end else if (tmr == CW'(HOLD_DLY - 1)) begin
          state_nxt = R_REPEAT;
          fire      = 1'b1;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt   = tmr + 1'b1;
`endif
        end
      end
`ifdef AUTOREPEAT_EN
      R_REPEAT: begin
        if (!held || other_hi) begin
          state_nxt = R_IDLE;
        end else if (tmr == CW'(RPT_PER - 1)) begin
          fire    = 1'b1;
          tmr_nxt = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
`endif
      default: state_nxt = R_IDLE;
    endcase
    if (!enable || clear) begin
      state_nxt = R_IDLE;
      fire      = 1'b0;
`ifdef AUTOREPEAT_EN
      tmr_nxt   = '0;
`endif
    end
  end

  always_comb begin
    up_nxt = fire & dir_up_nxt;
    dn_nxt = fire & ~dir_up_nxt;
  end

endmodule

// File: rtl/control_ajuste_campos.sv
// RTC time/date set-mode controller: field select, up/down strobes, inactivity timeout, cursor blink.
// Press-and-hold auto-repeat is built only when AUTOREPEAT_EN is defined.
module control_ajuste_campos
  import ajuste_pkg::*;
#(
  parameter int N_FIELDS  = DEF_N_FIELDS,
  parameter int HOLD_DLY  = DEF_HOLD_DLY,
  parameter int RPT_PER   = DEF_RPT_PER,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int BLINK_PER = DEF_BLINK_PER,
  parameter int CW        = DEF_CW
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       prog_mode,
  output logic       cursor_blink
);

  if (CW < $clog2(HOLD_DLY) || CW < $clog2(RPT_PER) ||
      CW < $clog2(TIMEOUT)  || CW < $clog2(BLINK_PER)) begin : g_cw_chk
    $error("CW too narrow for the timing parameters");
  end

  logic [4:0] btn, btn_d, btn_e;
  logic armed;
  logic any_btn, timeout_hit, fld_inc, fld_dec, stay_prog;
  mode_t state, state_nxt;
  logic [3:0] en_nxt;
  logic [CW-1:0] to_cnt, to_nxt, blk_cnt, blk_nxt;
  logic blink_nxt;

  assign btn = {btn_prog, btn_left, btn_right, btn_up, btn_down};
  // armed masks the first cycle after reset so a button held through reset is not an edge.
  assign btn_e = btn & ~btn_d & {5{armed}};
  assign any_btn = |btn;
  assign timeout_hit = (to_cnt == CW'(TIMEOUT - 1)) && !any_btn;
  assign stay_prog = (state == M_PROG) && (state_nxt == M_PROG);
  assign fld_inc = stay_prog & btn_e[2] & ~btn_e[3];
  assign fld_dec = stay_prog & btn_e[3] & ~btn_e[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_d        <= '0;
      armed        <= 1'b0;
      state        <= M_IDLE;
      en_count     <= F_NONE;
      to_cnt       <= '0;
      blk_cnt      <= '0;
      cursor_blink <= 1'b0;
    end else begin
      btn_d        <= btn;
      armed        <= 1'b1;
      state        <= state_nxt;
      en_count     <= en_nxt;
      to_cnt       <= to_nxt;
      blk_cnt      <= blk_nxt;
      cursor_blink <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:  if (btn_e[4]) state_nxt = M_PROG;
      M_PROG:  if (btn_e[4] || timeout_hit) state_nxt = M_IDLE;
      default: state_nxt = M_IDLE;
    endcase
  end

  always_comb begin
    en_nxt    = en_count;
    to_nxt    = to_cnt;
    blk_nxt   = blk_cnt;
    blink_nxt = cursor_blink;
    prog_mode = (state == M_PROG);
    if (state_nxt != M_PROG) begin
      en_nxt    = F_NONE;
      to_nxt    = '0;
      blk_nxt   = '0;
      blink_nxt = 1'b0;
    end else if (state == M_IDLE) begin
      en_nxt    = F_SS;
      to_nxt    = '0;
      blk_nxt   = '0;
      blink_nxt = 1'b1;
    end else begin
      to_nxt = any_btn ? '0 : to_cnt + 1'b1;
      if (fld_inc)
        en_nxt = (en_count == 4'(N_FIELDS)) ? F_SS : en_count + 4'd1;
      else if (fld_dec)
        en_nxt = (en_count == F_SS) ? 4'(N_FIELDS) : en_count - 4'd1;
      if (fld_inc || fld_dec) begin
        blk_nxt   = '0;
        blink_nxt = 1'b1;
      end else if (blk_cnt == CW'(BLINK_PER - 1)) begin
        blk_nxt   = '0;
        blink_nxt = ~cursor_blink;
      end else begin
        blk_nxt = blk_cnt + 1'b1;
      end
    end
  end

  gen_autorepeat
`ifdef AUTOREPEAT_EN
  #(
    .HOLD_DLY (HOLD_DLY),
    .RPT_PER  (RPT_PER),
    .CW       (CW)
  )
`endif
  u_rep (
    .clk      (clk),
    .reset    (reset),
    .enable   (stay_prog),
    .clear    (fld_inc | fld_dec),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .up_edge  (btn_e[1]),
    .dn_edge  (btn_e[0]),
    .up_pls   (enUP),
    .dn_pls   (enDOWN)
  );

endmodule

// File: doc/control_ajuste_campos.md
Name: control_ajuste_campos

Overview:
Time/date set-mode controller for the RTC display path. Converts debounced user buttons into the field-select code (en_count) and single-cycle enUP/enDOWN increment/decrement strobes consumed by the per-field BCD set counters (SS, MM, HH, DD, MES, AA). Adds press-and-hold auto-repeat, an inactivity timeout and a cursor blink signal for the VGA overlay.

Parameters:
N_FIELDS, 6, number of selectable fields; en_count codes 1..N_FIELDS (1=SS, 2=MM, 3=HH, 4=DD, 5=MES, 6=AA).
HOLD_DLY, 50000000, cycles a button must stay held before auto-repeat starts (0.5 s @100 MHz).
RPT_PER, 12500000, cycles between repeat strobes (~8 Hz).
TIMEOUT, 1000000000, idle cycles in PROG before automatic exit (10 s).
BLINK_PER, 25000000, cycles per half-period of cursor_blink.
CW, 30, width of the shared timer counters; must hold max(HOLD_DLY, RPT_PER, TIMEOUT).

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
btn_prog  in  1  debounced level; rising edge toggles program mode
btn_left  in  1  debounced level; rising edge selects previous field
btn_right  in  1  debounced level; rising edge selects next field
btn_up  in  1  debounced level; increment request
btn_down  in  1  debounced level; decrement request
en_count  out  4  active field code; 0 = not programming
enUP  out  1  one-cycle increment strobe
enDOWN  out  1  one-cycle decrement strobe
prog_mode  out  1  high while in PROG
cursor_blink  out  1  square wave for the selected-field highlight; 0 outside PROG

Behaviour:
- Reset (async, active-high): state IDLE, en_count=0, enUP=enDOWN=0, prog_mode=0, cursor_blink=0, all timers 0, edge-detect registers 0.
- Edge detection: one register per button; edge = btn & ~btn_d. Asserting a button during reset produces no edge after release of reset if it is still held.
- Mode FSM IDLE <-> PROG:
  - IDLE: btn_prog edge -> PROG, en_count=1, timeout counter cleared. Other buttons are ignored.
  - PROG: btn_prog edge -> IDLE, en_count=0. The timeout counter reaching TIMEOUT-1 with no button level high -> IDLE.
  - Any button level high clears the timeout counter.
- Field select (PROG only):
  - right edge: en_count+1, wrapping N_FIELDS->1.
  - left edge: en_count-1, wrapping 1->N_FIELDS.
  - Simultaneous left and right edges: no change.
  - A field change aborts any repeat in progress; the repeat FSM returns to R_IDLE.
- Repeat FSM (PROG only), states R_IDLE, R_DELAY, R_REPEAT:
  - R_IDLE: up edge XOR down edge -> one-cycle strobe on the matching output in the cycle after the edge; latch direction; go to R_DELAY with the timer cleared.
  - R_DELAY: latched button released -> R_IDLE. Timer reaches HOLD_DLY-1 -> strobe, go to R_REPEAT with the timer cleared.
  - R_REPEAT: strobe every RPT_PER cycles while the latched button is held. Release -> R_IDLE.
  - up and down both high in the same cycle, or the other direction pressed during a repeat: no strobe; go to R_IDLE. A new press requires both buttons released first.
- enUP and enDOWN are mutually exclusive, registered, exactly one cycle wide, and never asserted in IDLE.
- Leaving PROG (toggle or timeout) mid-repeat: strobes stop in the same cycle the state changes; the repeat FSM is forced to R_IDLE.
- cursor_blink toggles every BLINK_PER cycles in PROG. It restarts at 1 on PROG entry and on every field change.

Optional Feature:
AUTOREPEAT_EN.
- Defined: R_DELAY and R_REPEAT are implemented as described above.
- Undefined: exactly one strobe per up/down edge; holding a button produces no further strobes. HOLD_DLY and RPT_PER are unused, and no repeat timer logic is synthesized.

Decomposition:
- Package ajuste_pkg holds the field codes (F_NONE=0, F_SS=1, F_MM=2, F_HH=3, F_DD=4, F_MES=5, F_AA=6), the mode state encoding, the repeat state encoding and default timing constants.
- One sub-module, gen_autorepeat, contains the repeat FSM and its timer. Inputs: clk, reset, enable, clear, btn_up, btn_down, edge strobes. Outputs: up_pls, dn_pls.

Test Plan (HOLD_DLY=10, RPT_PER=4, TIMEOUT=50, BLINK_PER=3):
- Reset mid-repeat while btn_up is held -> all outputs 0 immediately; no enUP after release of reset until a fresh up edge in PROG.
- btn_prog pulse, then 7 btn_right pulses -> en_count sequence 1,2,3,4,5,6,1,2. One btn_left pulse -> 1; a further btn_left pulse -> 6.
- PROG, en_count=3, btn_up held 30 cycles -> enUP at cycle 1 after the edge, then at 11, 15, 19, 23, 27; 6 strobes total; enDOWN never asserted.
- btn_up and btn_down rising in the same cycle -> no strobes; state stays R_IDLE until both are released.
- PROG with no buttons for 50 cycles -> prog_mode=0, en_count=0. A button toggling at cycle 40 -> the timeout is pushed out 50 cycles past that cycle.
- AUTOREPEAT_EN undefined, btn_down held 30 cycles -> exactly one enDOWN. btn_up in IDLE -> no strobe.
